// File: rtl/sync_stable_bus.sv
// Multi-bit status synchroniser: per-bit flop chain followed by a stability filter
// that commits a word only after it has been seen unchanged for STABLE cycles.
module sync_stable_bus #(
    parameter int W           = 32,
    parameter int SYNC_STAGES = 2,
    parameter int STABLE      = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in,
    input  logic         hold,
    output logic [W-1:0] out,
    output logic         out_valid,
    output logic         upd,
    output logic [W-1:0] chg
);
    localparam int CW = $clog2(STABLE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t state_reg, state_next;

    logic [W-1:0]           s;
    logic [SYNC_STAGES-1:0] vld_reg;
    logic                   s_valid;
    logic [W-1:0]           cand_reg, cand_next;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic [W-1:0]           out_reg, out_next;
    logic [W-1:0]           chg_reg, chg_next;
    logic                   upd_reg, upd_next;
    logic                   out_valid_reg, out_valid_next;
    logic                   commit;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_reg;
            always_ff @(posedge clk) begin
                if (!rst_n) chain_reg <= '0;
                else        chain_reg <= {chain_reg[SYNC_STAGES-2:0], in[gi]};
            end
            assign s[gi] = chain_reg[SYNC_STAGES-1];
        end
    endgenerate

    // The cleared chain is not a real sample; the filter waits until the chain has
    // refilled from in, so the first word after reset loads cand at edge SYNC_STAGES+1.
    always_ff @(posedge clk) begin
        if (!rst_n) vld_reg <= '0;
        else        vld_reg <= {vld_reg[SYNC_STAGES-2:0], 1'b1};
    end
    assign s_valid = vld_reg[SYNC_STAGES-1];

    always_comb begin
        cand_next = cand_reg;
        cnt_next  = cnt_reg;
        if (s_valid) begin
            if (cnt_reg == '0 || s != cand_reg) begin
                cand_next = s;
                cnt_next  = CNT_ONE;
            end else if (cnt_reg != CNT_MAX) begin
                cnt_next = cnt_reg + CNT_ONE;
            end
        end
    end

    assign commit = (cnt_reg == CNT_MAX) && (s == cand_reg) && !hold &&
                    ((state_reg == INIT) || (cand_reg != out_reg));

    always_comb begin
        state_next     = state_reg;
        out_next       = out_reg;
        out_valid_next = out_valid_reg;
        upd_next       = 1'b0;
        chg_next       = '0;
        if (commit) begin
            state_next     = TRACK;
            out_next       = cand_reg;
            out_valid_next = 1'b1;
            upd_next       = 1'b1;
            chg_next       = cand_reg ^ out_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= INIT;
            cand_reg      <= '0;
            cnt_reg       <= '0;
            out_reg       <= '0;
            chg_reg       <= '0;
            upd_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cand_reg      <= cand_next;
            cnt_reg       <= cnt_next;
            out_reg       <= out_next;
            chg_reg       <= chg_next;
            upd_reg       <= upd_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign out       = out_reg;
    assign out_valid = out_valid_reg;
    assign upd       = upd_reg;
    assign chg       = chg_reg;
endmodule
